alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (SHALL be >= 4 and a power of two).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to launch an operation; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A, captured on an accepted start.
REQ-007 b  input  WIDTH  operand B, captured on an accepted start.
REQ-008 alucont  input  4  operation code, captured on an accepted start.
REQ-009 busy  output  1  high while an operation is in progress (any state other than IDLE).
REQ-010 done  output  1  one-cycle pulse when result, hi and lo are valid.
REQ-011 result  output  WIDTH  registered operation result, held until the next done.
REQ-012 zero  output  1  (result == 0), combinational from the result register.
REQ-013 bge  output  1  ~result[WIDTH-1], combinational from the result register.
REQ-014 hi, lo  output  WIDTH each  registered multiply/divide results, held until the next mul/div done.

Function
REQ-015 Opcodes SHALL be: 0000 a&b; 0001 a|b; 0010 a+b; 0110 a-b; 0111 unsigned a<b (1/0, zero-extended); 1000 a^b; 1001 ~(a|b); 1010 a<<sh; 1011 a>>sh (logical); 1100 unsigned multiply; 1101 unsigned divide; all other codes result 0.
REQ-016 Add, subtract and shift SHALL wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-017 States SHALL be IDLE, MUL, DIV and DONE.
REQ-018 IDLE with start=1 SHALL capture a, b and alucont and go to MUL (1100), to DIV (1101), or otherwise to DONE with result computed in the same edge.
REQ-019 The single-cycle latency SHALL be: start sampled at edge N, done=1 during the cycle following edge N+1 (DONE state).
REQ-020 MUL SHALL run an unsigned shift-add over exactly WIDTH cycles, then go to DONE with {hi,lo} = the 2*WIDTH-bit product and result = lo.
REQ-021 DIV SHALL run an unsigned restoring division over exactly WIDTH cycles, then go to DONE with lo = quotient, hi = remainder and result = quotient.
REQ-022 Divide by zero (b==0) SHALL still take WIDTH cycles and yield lo = all ones, hi = a and result = all ones.
REQ-023 The mul/div latency SHALL be: start at edge N, done high in the cycle after edge N+WIDTH+1.
REQ-024 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally; busy=1 in MUL, DIV and DONE.
REQ-025 start SHALL be ignored while busy=1, and operands changing while busy SHALL not affect the result.
REQ-026 A start asserted in the cycle IDLE is re-entered SHALL be accepted (back-to-back throughput of one op per 2 cycles for single-cycle ops).
REQ-027 Non-mul/div operations SHALL leave hi and lo unchanged.

Reset
REQ-028 reset=1 SHALL immediately force state=IDLE, with busy=0, done=0, result=0, hi=0, lo=0 and all internal iteration registers cleared (zero=1, bge=1).
REQ-029 reset asserted mid-MUL/DIV SHALL abort the operation with no done pulse, and the first start after release SHALL behave as from power-up.

Verification
REQ-030 WIDTH=32, start with a=7, b=5, alucont=0010 -> done one cycle after the DONE transition, result=12, zero=0, bge=1; a=5, b=7, 0110 -> result=0xFFFFFFFE, bge=0.
REQ-031 a=0xFFFFFFFF, b=0xFFFFFFFF, 1100 -> busy for 33 cycles, done at cycle 34, hi=0xFFFFFFFE, lo=0x00000001, result=0x00000001.
REQ-032 a=100, b=7, 1101 -> lo=14, hi=2, result=14; a=100, b=0, 1101 -> lo=0xFFFFFFFF, hi=100.
REQ-033 Start MUL, toggle start/a/b every cycle while busy -> exactly one done with the product of the originally captured operands.
REQ-034 Assert reset at iteration 10 of DIV -> outputs zero asynchronously, no done pulse, next 0111 op with a=3, b=9 returns result=1.
REQ-035 Re-run REQ-030/031 with WIDTH=8: a=0xFF, b=0xFF, 1100 -> hi=0xFE, lo=0x01, done 9 cycles after start; alucont=1010, a=0x01, b=0x07 -> result=0x80.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative unsigned
// shift-add multiply and restoring divide, each taking WIDTH cycles.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alucont,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             bge,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [SHW-1:0] LastCnt = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_opb;
  logic [SHW-1:0]   r_cnt;

  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH:0]   w_mul_addend;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_rem;
  logic [WIDTH-1:0] w_mul_quo;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_sub;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;

  assign w_sh = b[SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (alucont)
      4'b0000: w_alu = a & b;
      4'b0001: w_alu = a | b;
      4'b0010: w_alu = a + b;
      4'b0110: w_alu = a - b;
      4'b0111: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b1000: w_alu = a ^ b;
      4'b1001: w_alu = ~(a | b);
      4'b1010: w_alu = a << w_sh;
      4'b1011: w_alu = a >> w_sh;
      default: w_alu = '0;
    endcase
  end

  // Multiply: r_rem holds the running high half, r_quo the multiplier shifting
  // out LSB-first while product bits shift in from the top.
  assign w_mul_addend = r_quo[0] ? {1'b0, r_opb} : '0;
  assign w_mul_sum    = {1'b0, r_rem} + w_mul_addend;
  assign w_mul_rem    = w_mul_sum[WIDTH:1];
  assign w_mul_quo    = {w_mul_sum[0], r_quo[WIDTH-1:1]};

  // Divide: partial remainder always stays below 2^WIDTH, so the subtraction
  // only needs WIDTH bits once the compare has passed. b==0 naturally yields
  // all-ones quotient and remainder == a.
  assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opb;
  assign w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
  assign w_div_quo   = {r_quo[WIDTH-2:0], w_div_ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_rem <= '0;
            r_quo <= a;
            r_opb <= b;
            r_cnt <= '0;
            case (alucont)
              4'b1100: r_state <= StMul;
              4'b1101: r_state <= StDiv;
              default: begin
                r_result <= w_alu;
                r_state  <= StDone;
              end
            endcase
          end
        end
        StMul: begin
          r_rem <= w_mul_rem;
          r_quo <= w_mul_quo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LastCnt) begin
            r_hi     <= w_mul_rem;
            r_lo     <= w_mul_quo;
            r_result <= w_mul_quo;
            r_state  <= StDone;
          end
        end
        StDiv: begin
          r_rem <= w_div_rem;
          r_quo <= w_div_quo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LastCnt) begin
            r_hi     <= w_div_rem;
            r_lo     <= w_div_quo;
            r_result <= w_div_quo;
            r_state  <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy   = (r_state != StIdle);
  assign done   = r_done;
  assign result = r_result;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign zero   = (r_result == '0);
  assign bge    = ~r_result[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=32 and WIDTH=8 instances, scoreboard of expected
// results pushed at launch and popped when done pulses.
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sel8;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alucont;

  logic        busy32, done32, zero32, bge32;
  logic [31:0] result32, hi32, lo32;
  logic        busy8, done8, zero8, bge8;
  logic [7:0]  result8, hi8, lo8;

  logic        start32, start8;
  logic        d_busy, d_done, d_zero, d_bge;
  logic [31:0] d_result, d_hi, d_lo;

  assign start32  = start & ~sel8;
  assign start8   = start & sel8;
  assign d_busy   = sel8 ? busy8 : busy32;
  assign d_done   = sel8 ? done8 : done32;
  assign d_zero   = sel8 ? zero8 : zero32;
  assign d_bge    = sel8 ? bge8 : bge32;
  assign d_result = sel8 ? {24'h0, result8} : result32;
  assign d_hi     = sel8 ? {24'h0, hi8} : hi32;
  assign d_lo     = sel8 ? {24'h0, lo8} : lo32;

  alu_seq #(.WIDTH(32)) u_dut32 (
    .clk     (clk),
    .reset   (reset),
    .start   (start32),
    .a       (a),
    .b       (b),
    .alucont (alucont),
    .busy    (busy32),
    .done    (done32),
    .result  (result32),
    .zero    (zero32),
    .bge     (bge32),
    .hi      (hi32),
    .lo      (lo32)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .reset   (reset),
    .start   (start8),
    .a       (a[7:0]),
    .b       (b[7:0]),
    .alucont (alucont),
    .busy    (busy8),
    .done    (done8),
    .result  (result8),
    .zero    (zero8),
    .bge     (bge8),
    .hi      (hi8),
    .lo      (lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    bit          w8;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi[2];
  logic [31:0] m_lo[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model built on native operators; tracks hi/lo per width.
  task automatic push_exp(input bit w8, input logic [3:0] op, input logic [31:0] ia,
                          input logic [31:0] ib);
    logic [63:0] mask, aa, bb, p;
    int          sh, w;
    exp_t        e;
    w    = w8 ? 8 : 32;
    mask = w8 ? 64'hFF : 64'hFFFF_FFFF;
    aa   = {32'h0, ia} & mask;
    bb   = {32'h0, ib} & mask;
    sh   = w8 ? int'(ib[2:0]) : int'(ib[4:0]);
    e.hi = m_hi[w8];
    e.lo = m_lo[w8];
    e.lat = 1;
    e.w8 = w8;
    p    = 64'h0;
    case (op)
      4'b0000: p = aa & bb;
      4'b0001: p = aa | bb;
      4'b0010: p = (aa + bb) & mask;
      4'b0110: p = (aa - bb) & mask;
      4'b0111: p = (aa < bb) ? 64'd1 : 64'd0;
      4'b1000: p = aa ^ bb;
      4'b1001: p = ~(aa | bb) & mask;
      4'b1010: p = (aa << sh) & mask;
      4'b1011: p = aa >> sh;
      4'b1100: begin
        p    = aa * bb;
        e.hi = 32'((p >> w) & mask);
        e.lo = 32'(p & mask);
        p    = p & mask;
        e.lat = w + 1;
      end
      4'b1101: begin
        if (bb == 0) begin
          e.lo = 32'(mask);
          e.hi = 32'(aa);
        end else begin
          e.lo = 32'(aa / bb);
          e.hi = 32'(aa % bb);
        end
        p    = {32'h0, e.lo};
        e.lat = w + 1;
      end
      default: p = 64'h0;
    endcase
    e.res = 32'(p);
    m_hi[w8] = e.hi;
    m_lo[w8] = e.lo;
    sb.push_back(e);
  endtask

  task automatic compare_pop(input string tag, output int lat);
    exp_t e;
    lat = 0;
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e   = sb.pop_front();
    lat = e.lat;
    check({tag, "_result"}, d_result, e.res);
    check({tag, "_hi"}, d_hi, e.hi);
    check({tag, "_lo"}, d_lo, e.lo);
    check({tag, "_zero"}, {31'h0, d_zero}, {31'h0, e.res == 32'h0});
    check({tag, "_bge"}, {31'h0, d_bge}, {31'h0, ~(e.w8 ? e.res[7] : e.res[31])});
  endtask

  task automatic run_op(input string tag, input bit w8, input logic [3:0] op,
                        input logic [31:0] ia, input logic [31:0] ib, input bit toggle);
    int cyc, nbusy, lat;
    bit got;
    sel8 = w8;
    push_exp(w8, op, ia, ib);
    a = ia;
    b = ib;
    alucont = op;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    nbusy = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (d_busy) nbusy++;
      @(posedge clk);
      #1;
      cyc++;
      if (d_done) got = 1'b1;
      else if (toggle) begin
        start = ~start;
        a = $urandom;
        b = $urandom;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'h0, got}, 32'd1);
    if (got) begin
      compare_pop(tag, lat);
      check({tag, "_latency"}, 32'(cyc), 32'(lat));
      check({tag, "_busy_cycles"}, 32'(nbusy), 32'(lat));
    end else begin
      void'(sb.pop_front());
    end
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'h0, d_done}, 32'd0);
    check({tag, "_idle_after"}, {31'h0, d_busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag, input bit w8);
    sel8 = w8;
    #0;
    check({tag, "_busy"}, {31'h0, d_busy}, 32'd0);
    check({tag, "_done"}, {31'h0, d_done}, 32'd0);
    check({tag, "_result"}, d_result, 32'h0);
    check({tag, "_hi"}, d_hi, 32'h0);
    check({tag, "_lo"}, d_lo, 32'h0);
    check({tag, "_zero"}, {31'h0, d_zero}, 32'd1);
    check({tag, "_bge"}, {31'h0, d_bge}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ops[12];
    logic [31:0] ra, rb;
    int lat;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000,
            4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b0011};
    m_hi = '{32'h0, 32'h0};
    m_lo = '{32'h0, 32'h0};
    reset = 1'b1;
    start = 1'b0;
    sel8 = 1'b0;
    a = '0;
    b = '0;
    alucont = '0;
    #12;
    check_reset_outputs("por32", 1'b0);
    check_reset_outputs("por8", 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_op("add32", 1'b0, 4'b0010, 32'd7, 32'd5, 1'b0);
    check("add32_const", d_result, 32'd12);
    run_op("sub32", 1'b0, 4'b0110, 32'd5, 32'd7, 1'b0);
    check("sub32_const", d_result, 32'hFFFF_FFFE);
    run_op("mul32_max", 1'b0, 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mul32_hi_const", d_hi, 32'hFFFF_FFFE);
    run_op("and32_keep", 1'b0, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
    run_op("div32", 1'b0, 4'b1101, 32'd100, 32'd7, 1'b0);
    check("div32_lo_const", d_lo, 32'd14);
    run_op("div32_by0", 1'b0, 4'b1101, 32'd100, 32'd0, 1'b0);
    check("div32_by0_hi_const", d_hi, 32'd100);
    run_op("mul32_toggle", 1'b0, 4'b1100, 32'h1234_5678, 32'h9ABC_DEF1, 1'b1);
    run_op("bad32", 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h1, 1'b0);

    run_op("add8", 1'b1, 4'b0010, 32'hFF, 32'h01, 1'b0);
    run_op("mul8_max", 1'b1, 4'b1100, 32'hFF, 32'hFF, 1'b0);
    check("mul8_hi_const", d_hi, 32'hFE);
    run_op("sll8", 1'b1, 4'b1010, 32'h01, 32'h07, 1'b0);
    check("sll8_const", d_result, 32'h80);
    run_op("div8_by0", 1'b1, 4'b1101, 32'h5A, 32'h00, 1'b0);

    // Back-to-back single-cycle ops; operand change while busy must be ignored.
    sel8 = 1'b0;
    push_exp(1'b0, 4'b0010, 32'd1, 32'd2);
    a = 32'd1;
    b = 32'd2;
    alucont = 4'b0010;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 32'd10;
    b = 32'd20;
    check("b2b_busy", {31'h0, d_busy}, 32'd1);
    @(posedge clk);
    #1;
    check("b2b_done1", {31'h0, d_done}, 32'd1);
    compare_pop("b2b_op1", lat);
    push_exp(1'b0, 4'b0010, 32'd10, 32'd20);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_done2", {31'h0, d_done}, 32'd1);
    compare_pop("b2b_op2", lat);
    @(posedge clk);
    #1;

    // Abort a divide mid-run with an asynchronous reset.
    sel8 = 1'b0;
    a = 32'd1000;
    b = 32'd7;
    alucont = 4'b1101;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("abort32", 1'b0);
    check_reset_outputs("abort8", 1'b1);
    m_hi = '{32'h0, 32'h0};
    m_lo = '{32'h0, 32'h0};
    sel8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", {31'h0, d_done}, 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (d_done) check("abort_late_done", {31'h0, d_done}, 32'd0);
    end
    run_op("sltu_after_abort", 1'b0, 4'b0111, 32'd3, 32'd9, 1'b0);

    for (int i = 0; i < 16; i++) begin
      logic [3:0] op;
      op = ops[$urandom_range(0, 11)];
      ra = $urandom;
      rb = (op == 4'b1101) ? 32'($urandom_range(0, 300)) : $urandom;
      run_op($sformatf("rand%0d", i), i[0], op, ra, rb, 1'b0);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
